// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with IF/ID register, stall and one-bubble redirect
// Optional perf counters (o_perf_fetched / o_perf_bubbles) enabled by INST_FETCH_PERF_CNT_EN.
module inst_fetch #(
    parameter int PC_WIDTH       = 8,
    parameter int INSTR_WIDTH    = 18,
    parameter int OPCODE_WIDTH   = 4,
    parameter int FUNCTION_WIDTH = 8,
    parameter int ADDRESS_WIDTH  = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_stall,
    input  logic                      i_redirect,
    input  logic [PC_WIDTH-1:0]       i_redirect_pc,
    output logic [PC_WIDTH-1:0]       o_imem_addr,
    input  logic [INSTR_WIDTH-1:0]    i_imem_rdata,
    output logic                      o_if_valid,
    output logic [INSTR_WIDTH-1:0]    o_if_instr,
    output logic [PC_WIDTH-1:0]       o_if_pc,
    output logic [OPCODE_WIDTH-1:0]   o_opcode,
    output logic [ADDRESS_WIDTH-1:0]  o_rd,
    output logic [ADDRESS_WIDTH-1:0]  o_rs1,
    output logic [ADDRESS_WIDTH-1:0]  o_rs2,
    output logic [FUNCTION_WIDTH-1:0] o_funct,
    output logic [7:0]                o_imm8,
    output logic [13:0]               o_imm14
`ifdef INST_FETCH_PERF_CNT_EN
   ,output logic [15:0]               o_perf_fetched,
    output logic [15:0]               o_perf_bubbles
`endif
);

    localparam int RD_LSB  = INSTR_WIDTH - OPCODE_WIDTH - ADDRESS_WIDTH;
    localparam int RS1_LSB = RD_LSB - ADDRESS_WIDTH;
    localparam int RS2_LSB = RS1_LSB - ADDRESS_WIDTH;

    typedef enum logic [1:0] {PRIME, RUN, STALL} state_t;

    state_t                   state_q, state_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [PC_WIDTH-1:0]      fl_pc_q, fl_pc_d;
    logic                     fl_valid_q, fl_valid_d;
    logic                     if_valid_q, if_valid_d;
    logic [INSTR_WIDTH-1:0]   if_instr_q, if_instr_d;
    logic [PC_WIDTH-1:0]      if_pc_q, if_pc_d;
    logic                     load_new;

    // Stall re-reads the in-flight address so i_imem_rdata stays valid for it.
    assign o_imem_addr = i_redirect ? i_redirect_pc :
                         i_stall    ? fl_pc_q       : pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fl_pc_d    = fl_pc_q;
        fl_valid_d = fl_valid_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        load_new   = 1'b0;
        if (i_redirect) begin
            if_valid_d = 1'b0;
            fl_pc_d    = i_redirect_pc;
            fl_valid_d = 1'b1;
            pc_d       = i_redirect_pc + PC_WIDTH'(1);
            state_d    = RUN;
        end else if (i_stall) begin
            state_d = (state_q == PRIME) ? PRIME : STALL;
        end else begin
            if_valid_d = fl_valid_q;
            if_instr_d = i_imem_rdata;
            if_pc_d    = fl_pc_q;
            fl_pc_d    = o_imem_addr;
            fl_valid_d = 1'b1;
            pc_d       = o_imem_addr + PC_WIDTH'(1);
            load_new   = fl_valid_q;
            state_d    = RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= PRIME;
            pc_q       <= '0;
            fl_pc_q    <= '0;
            fl_valid_q <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fl_pc_q    <= fl_pc_d;
            fl_valid_q <= fl_valid_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign o_if_valid = if_valid_q;
    assign o_if_instr = if_instr_q;
    assign o_if_pc    = if_pc_q;

    // Field slices read as zero while the slot is a bubble.
    assign o_opcode = if_valid_q ? if_instr_q[INSTR_WIDTH-1 -: OPCODE_WIDTH] : '0;
    assign o_rd     = if_valid_q ? if_instr_q[RD_LSB +: ADDRESS_WIDTH]       : '0;
    assign o_rs1    = if_valid_q ? if_instr_q[RS1_LSB +: ADDRESS_WIDTH]      : '0;
    assign o_rs2    = if_valid_q ? if_instr_q[RS2_LSB +: ADDRESS_WIDTH]      : '0;
    assign o_funct  = if_valid_q ? if_instr_q[FUNCTION_WIDTH-1:0]            : '0;
    assign o_imm8   = if_valid_q ? if_instr_q[7:0]                           : '0;
    assign o_imm14  = if_valid_q ? if_instr_q[13:0]                          : '0;

`ifdef INST_FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched_q, perf_bubbles_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            if (load_new && (perf_fetched_q != 16'hFFFF))
                perf_fetched_q <= perf_fetched_q + 16'd1;
            if (i_redirect && (perf_bubbles_q != 16'hFFFF))
                perf_bubbles_q <= perf_bubbles_q + 16'd1;
        end
    end

    assign o_perf_fetched = perf_fetched_q;
    assign o_perf_bubbles = perf_bubbles_q;
`else
    logic unused_load_new;
    assign unused_load_new = load_new;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - table-driven bench for inst_fetch with a synchronous-read memory model
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n, stall, redir;
    logic [7:0]  rpc;
    logic [7:0]  imem_addr;
    logic [17:0] imem_rdata = '0;
    logic        if_valid;
    logic [17:0] if_instr;
    logic [7:0]  if_pc;
    logic [3:0]  opcode;
    logic [1:0]  rd, rs1, rs2;
    logic [7:0]  funct, imm8;
    logic [13:0] imm14;
`ifdef INST_FETCH_PERF_CNT_EN
    logic [15:0] perf_fetched, perf_bubbles;
`endif

    always #5 clk = ~clk;

    inst_fetch dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_stall       (stall),
        .i_redirect    (redir),
        .i_redirect_pc (rpc),
        .o_imem_addr   (imem_addr),
        .i_imem_rdata  (imem_rdata),
        .o_if_valid    (if_valid),
        .o_if_instr    (if_instr),
        .o_if_pc       (if_pc),
        .o_opcode      (opcode),
        .o_rd          (rd),
        .o_rs1         (rs1),
        .o_rs2         (rs2),
        .o_funct       (funct),
        .o_imm8        (imm8),
        .o_imm14       (imm14)
`ifdef INST_FETCH_PERF_CNT_EN
       ,.o_perf_fetched(perf_fetched),
        .o_perf_bubbles(perf_bubbles)
`endif
    );

    logic [17:0] mem [256];

    always @(posedge clk) imem_rdata <= mem[imem_addr];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic       stall;
        logic       redir;
        logic [7:0] rpc;
        logic [7:0] exp_addr;
        logic       exp_valid;
        logic [7:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic j, input logic [7:0] t,
                       input logic [7:0] a, input logic v, input logic [7:0] p);
        vec_t e;
        e.rst_n = r; e.stall = s; e.redir = j; e.rpc = t;
        e.exp_addr = a; e.exp_valid = v; e.exp_pc = p;
        vecs.push_back(e);
    endtask

    task automatic chk_fields(input string tag, input logic [3:0] op, input logic [1:0] d,
                              input logic [1:0] s1, input logic [1:0] s2, input logic [7:0] fn,
                              input logic [13:0] i14);
        chk({tag, "_opcode"}, 32'(opcode), 32'(op));
        chk({tag, "_rd"},     32'(rd),     32'(d));
        chk({tag, "_rs1"},    32'(rs1),    32'(s1));
        chk({tag, "_rs2"},    32'(rs2),    32'(s2));
        chk({tag, "_funct"},  32'(funct),  32'(fn));
        chk({tag, "_imm8"},   32'(imm8),   32'(fn));
        chk({tag, "_imm14"},  32'(imm14),  32'(i14));
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 18'h100 + 18'(a);
        rst_n = 1'b0; stall = 1'b0; redir = 1'b0; rpc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", 32'(if_instr), 32'd0);
        chk("rst_pc",    32'(if_pc),    32'd0);
        chk("rst_addr",  32'(imem_addr), 32'd0);
        chk("rst_imm14", 32'(imm14),    32'd0);

        // rst_n, stall, redirect, target, issued addr, IF/ID valid, IF/ID pc
        add(1,0,0,8'h00, 8'h00,0,8'h00);
        add(1,0,0,8'h00, 8'h01,1,8'h00);
        add(1,0,0,8'h00, 8'h02,1,8'h01);
        add(1,0,0,8'h00, 8'h03,1,8'h02);
        add(1,0,0,8'h00, 8'h04,1,8'h03);
        add(1,0,0,8'h00, 8'h05,1,8'h04);
        add(1,0,0,8'h00, 8'h06,1,8'h05);
        add(1,1,0,8'h00, 8'h06,1,8'h05);
        add(1,1,0,8'h00, 8'h06,1,8'h05);
        add(1,1,0,8'h00, 8'h06,1,8'h05);
        add(1,0,0,8'h00, 8'h07,1,8'h06);
        add(1,0,0,8'h00, 8'h08,1,8'h07);
        add(1,0,0,8'h00, 8'h09,1,8'h08);
        add(1,0,0,8'h00, 8'h0A,1,8'h09);
        add(1,0,0,8'h00, 8'h0B,1,8'h0A);
        add(1,0,1,8'h40, 8'h40,0,8'h00);
        add(1,0,0,8'h00, 8'h41,1,8'h40);
        add(1,0,0,8'h00, 8'h42,1,8'h41);
        add(1,1,1,8'h20, 8'h20,0,8'h00);
        add(1,0,0,8'h00, 8'h21,1,8'h20);
        add(1,0,0,8'h00, 8'h22,1,8'h21);
        add(1,0,1,8'hFE, 8'hFE,0,8'h00);
        add(1,0,0,8'h00, 8'hFF,1,8'hFE);
        add(1,0,0,8'h00, 8'h00,1,8'hFF);
        add(1,0,0,8'h00, 8'h01,1,8'h00);
        add(1,0,0,8'h00, 8'h02,1,8'h01);
        add(1,1,0,8'h00, 8'h02,1,8'h01);
        add(0,1,0,8'h00, 8'h02,0,8'h00);
        add(1,0,0,8'h00, 8'h00,0,8'h00);
        add(1,0,0,8'h00, 8'h01,1,8'h00);
        add(1,0,0,8'h00, 8'h02,1,8'h01);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n;
            stall = vecs[i].stall;
            redir = vecs[i].redir;
            rpc   = vecs[i].rpc;
            #1;
            chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
            if (!vecs[i].rst_n) begin
                chk($sformatf("v%0d_rst_pc", i),    32'(if_pc),    32'd0);
                chk($sformatf("v%0d_rst_instr", i), 32'(if_instr), 32'd0);
            end else if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_pc", i),    32'(if_pc),    32'(vecs[i].exp_pc));
                chk($sformatf("v%0d_instr", i), 32'(if_instr), 32'(mem[vecs[i].exp_pc]));
            end
`ifdef INST_FETCH_PERF_CNT_EN
            if (i == 15) chk("perf_bubbles_first", 32'(perf_bubbles), 32'd1);
`endif
        end

        // Field decode: redirect into patched words at pc 3 and 4
        mem[3] = 18'h01B03;
        mem[4] = 18'h2E7A5;
        rst_n = 1'b1; stall = 1'b0; redir = 1'b1; rpc = 8'h03;
        #1;
        chk("dec_addr", 32'(imem_addr), 32'h03);
        @(posedge clk); #1;
        redir = 1'b0;
        chk("dec_bubble_valid", 32'(if_valid), 32'd0);
        chk_fields("bubble", 4'h0, 2'd0, 2'd0, 2'd0, 8'h00, 14'h0000);
        @(posedge clk); #1;
        chk("dec3_pc", 32'(if_pc), 32'h03);
        chk_fields("pc3", 4'h0, 2'd1, 2'd2, 2'd3, 8'h03, 14'h1B03);
        @(posedge clk); #1;
        chk("dec4_pc", 32'(if_pc), 32'h04);
        chk_fields("pc4", 4'hB, 2'd2, 2'd1, 2'd3, 8'hA5, 14'h27A5);
`ifdef INST_FETCH_PERF_CNT_EN
        chk("perf_fetched", 32'(perf_fetched), 32'd4);
        chk("perf_bubbles", 32'(perf_bubbles), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage plus IF/ID pipeline register, directly upstream of the instruction decoder.
- Generates the PC, drives a synchronous-read instruction memory, and registers each returned 18-bit instruction.
- Splits the instruction into fields: opcode to the decoder's i_opcode, funct to i_funct, and register/immediate fields.
- Supports stall from downstream hazard logic and redirect (taken BNE / JMP) with a one-slot flush.

Parameters:
- PC_WIDTH, 8, instruction address width; PC wraps modulo 2^PC_WIDTH.
- INSTR_WIDTH, 18, instruction width.
- OPCODE_WIDTH, 4, opcode field width [17:14].
- FUNCTION_WIDTH, 8, funct field width [7:0].
- ADDRESS_WIDTH, 2, register-address field width.

Ports:
- i_clk  input  1  clock, all state updates on the rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_stall  input  1  hold the PC and IF/ID contents.
- i_redirect  input  1  branch taken or jump; fetch from i_redirect_pc.
- i_redirect_pc  input  PC_WIDTH  redirect target.
- o_imem_addr  output  PC_WIDTH  instruction memory address; data returns 1 cycle later.
- i_imem_rdata  input  INSTR_WIDTH  instruction memory read data.
- o_if_valid  output  1  IF/ID holds a real instruction.
- o_if_instr  output  INSTR_WIDTH  registered instruction.
- o_if_pc  output  PC_WIDTH  PC of o_if_instr.
- o_opcode  output  OPCODE_WIDTH  o_if_instr[17:14].
- o_rd  output  ADDRESS_WIDTH  [13:12].
- o_rs1  output  ADDRESS_WIDTH  [11:10].
- o_rs2  output  ADDRESS_WIDTH  [9:8].
- o_funct  output  FUNCTION_WIDTH  [7:0].
- o_imm8  output  8  [7:0], I-type immediate.
- o_imm14  output  14  [13:0], J-type immediate.

Behaviour:
- Internal registers:
  - pc_q: next address to issue.
  - fl_pc_q / fl_valid_q: the address whose data is on i_imem_rdata this cycle.
  - IF/ID register: valid, instr, pc.
- Field outputs are pure slices of o_if_instr and are forced to 0 when o_if_valid=0.
- Reset (i_rst_n=0 at an edge):
  - pc_q=0, fl_pc_q=0, fl_valid_q=0.
  - o_if_valid=0, o_if_instr=0, o_if_pc=0.
- Address mux, in priority order:
  - i_redirect → i_redirect_pc.
  - else i_stall → fl_pc_q (re-read the in-flight slot so its data stays stable).
  - else pc_q.
- FSM states: PRIME, RUN, STALL.
  - PRIME: entered on reset. fl_valid_q=0. The next edge issues pc 0 and goes to RUN.
  - RUN: each edge does IF/ID ← {fl_valid_q, i_imem_rdata, fl_pc_q}; fl_pc_q ← o_imem_addr; fl_valid_q ← 1; pc_q ← o_imem_addr+1 (wraps).
  - STALL: occupied while i_stall=1 and i_redirect=0. pc_q, fl_* and IF/ID all hold. Return to RUN on the first edge with i_stall=0.
- Redirect, from any non-reset state:
  - o_if_valid ← 0 (flush).
  - fl_pc_q ← i_redirect_pc, fl_valid_q ← 1, pc_q ← i_redirect_pc+1.
  - Next state RUN.
- Priority: reset > redirect > stall > run. Redirect during stall flushes and clears the stall state.
- Latency:
  - An address issued at edge k appears on o_if_* after edge k+1.
  - After reset deassert, the first valid instruction (pc 0) is visible after the 2nd edge.
  - Redirect penalty is exactly one bubble cycle.
- Wrap: pc 2^PC_WIDTH-1 is followed by 0 with no bubble.
- A reset asserted mid-stall or mid-redirect overrides everything; the fetch sequence restarts at pc 0.

Optional Feature:
- Macro: INST_FETCH_PERF_CNT_EN.
- With the macro defined, add two 16-bit saturating counters, cleared by reset:
  - o_perf_fetched: increments on every edge where o_if_valid becomes 1 with new data.
  - o_perf_bubbles: increments on every edge where o_if_valid becomes 0 due to redirect.
- Without the macro, neither port nor the counter logic exists.

Test Plan:
- Reset then free-run, memory mem[a]=a+0x100 → o_if_valid=0 for 1 cycle after the first edge, then o_if_pc=0,1,2… with o_if_instr=0x100,0x101,0x102 on consecutive cycles.
- Instr 18'b0000_01_10_11_00000011 at pc 3 → o_opcode=0, o_rd=1, o_rs1=2, o_rs2=3, o_funct=0x03, o_imm8=0x03.
- i_stall high 3 cycles while IF/ID holds pc 5 → o_if_pc=5 and o_if_instr held for 3 cycles, o_imem_addr=6 during the stall, then pc 6,7 follow with no loss or duplicate.
- i_redirect=1, i_redirect_pc=0x40 while at pc 10 → one cycle o_if_valid=0, then o_if_pc=0x40, 0x41.
- Redirect and stall asserted together, target 0x20 → redirect wins; pc 0x20 appears after the bubble. Also run across the wrap boundary: pc 0xFE, 0xFF, 0x00, 0x01 with no bubble.
- i_rst_n low for one edge mid-stall → all outputs 0; restart at pc 0. With INST_FETCH_PERF_CNT_EN, after scenario 4 o_perf_bubbles=1.
